bus_bridge_master_ctrl: RTL and testbench

Remote-side counterpart of the UART bus bridge slave. It consumes the 21-bit request frames received over the bridge UART and replays each one as a transaction on the local serial bus through a master-port request interface. For reads, it returns the 8-bit read data to the remote bridge over UART TX. A small frame FIFO absorbs back-to-back frames while the local bus is busy.

---
 rtl/bridge_pkg.sv | 32 +++
 rtl/bridge_frame_fifo.sv | 61 ++++++
 rtl/bus_bridge_master_ctrl.sv | 148 ++++++++++++++
 tb/tb_bus_bridge_master_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared bridge definitions: frame field layout and FSM state encoding.
// The bus_bridge_slave uses the same layout on the other end of the link.
package bridge_pkg;

  localparam int BRIDGE_DATA_WIDTH = 8;
  localparam int BRIDGE_ADDR_WIDTH = 12;

  function automatic int frame_width(input int dw, input int aw);
    return dw + aw + 1;
  endfunction

  function automatic int mode_bit(input int dw, input int aw);
    return dw + aw;
  endfunction

  function automatic int wdata_lsb(input int aw);
    return aw;
  endfunction

  localparam int FRAME_WIDTH = frame_width(BRIDGE_DATA_WIDTH, BRIDGE_ADDR_WIDTH);
  localparam int MODE_BIT    = mode_bit(BRIDGE_DATA_WIDTH, BRIDGE_ADDR_WIDTH);
  localparam int WDATA_LSB   = wdata_lsb(BRIDGE_ADDR_WIDTH);
  localparam int ADDR_LSB    = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESP    = 2'd2,
    ST_TX_HOLD = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/bridge_frame_fifo.sv
// Synchronous first-word-fall-through FIFO for received request frames.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module bridge_frame_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == CNT_W'(0));
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // storage array carries no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_bridge_master_ctrl.sv
// Replays UART-received request frames as local bus transactions, one at a time,
// and returns read data (or 0 after a timeout) over UART TX.
module bus_bridge_master_ctrl #(
  parameter int DATA_WIDTH     = bridge_pkg::BRIDGE_DATA_WIDTH,
  parameter int ADDR_WIDTH     = bridge_pkg::BRIDGE_ADDR_WIDTH,
  parameter int FRAME_WIDTH    = DATA_WIDTH + ADDR_WIDTH + 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   u_rx_ready,
  input  logic [FRAME_WIDTH-1:0] u_rx_data,
  input  logic                   u_tx_busy,
  output logic [DATA_WIDTH-1:0]  u_tx_data,
  output logic                   u_tx_en,
  output logic                   req_valid,
  output logic                   req_mode,
  output logic [ADDR_WIDTH-1:0]  req_addr,
  output logic [DATA_WIDTH-1:0]  req_wdata,
  input  logic                   req_done,
  input  logic [DATA_WIDTH-1:0]  req_rdata,
  output logic                   fifo_overflow,
  output logic                   timeout_err
);

  import bridge_pkg::*;

  localparam int MODE_POS  = mode_bit(DATA_WIDTH, ADDR_WIDTH);
  localparam int WDATA_POS = wdata_lsb(ADDR_WIDTH);
  localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e          state, state_nxt;
  logic [CNT_W-1:0]       tmo_cnt, tmo_cnt_nxt;
  logic                   valid_nxt, mode_nxt, tx_en_nxt, tmo_err_nxt, ovf_nxt;
  logic [ADDR_WIDTH-1:0]  addr_nxt;
  logic [DATA_WIDTH-1:0]  wdata_nxt, tx_data_nxt;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [FRAME_WIDTH-1:0] fifo_dout;

  bridge_frame_fifo #(
    .WIDTH (FRAME_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (u_rx_ready),
    .pop   (fifo_pop),
    .din   (u_rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // next-state and next-output logic; every output is registered below
  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    valid_nxt   = req_valid;
    mode_nxt    = req_mode;
    addr_nxt    = req_addr;
    wdata_nxt   = req_wdata;
    tx_data_nxt = u_tx_data;
    tx_en_nxt   = 1'b0;
    tmo_err_nxt = timeout_err;
    fifo_pop    = 1'b0;
    // a dropped frame is one that finds the FIFO full with no pop freeing a slot
    ovf_nxt     = fifo_overflow | (u_rx_ready & fifo_full & ~fifo_pop);
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          valid_nxt   = 1'b1;
          mode_nxt    = fifo_dout[MODE_POS];
          wdata_nxt   = fifo_dout[WDATA_POS +: DATA_WIDTH];
          addr_nxt    = fifo_dout[ADDR_WIDTH-1:0];
          tmo_cnt_nxt = '0;
          state_nxt   = ST_ISSUE;
        end else begin
          state_nxt = ST_IDLE;
        end
        ovf_nxt = fifo_overflow | (u_rx_ready & fifo_full & ~fifo_pop);
      end
      ST_ISSUE: begin
        if (req_done) begin
          valid_nxt = 1'b0;
          if (req_mode) begin
            state_nxt = ST_IDLE;
          end else begin
            tx_data_nxt = req_rdata;
            state_nxt   = ST_RESP;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          valid_nxt   = 1'b0;
          tmo_err_nxt = 1'b1;
          if (req_mode) begin
            state_nxt = ST_IDLE;
          end else begin
            tx_data_nxt = '0;
            state_nxt   = ST_RESP;
          end
        end else begin
          tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (!u_tx_busy) begin
          tx_en_nxt = 1'b1;
          state_nxt = ST_TX_HOLD;
        end else begin
          state_nxt = ST_RESP;
        end
      end
      // one dead cycle lets the UART raise busy before anything else is issued
      ST_TX_HOLD: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      tmo_cnt       <= '0;
      req_valid     <= 1'b0;
      req_mode      <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      u_tx_data     <= '0;
      u_tx_en       <= 1'b0;
      timeout_err   <= 1'b0;
      fifo_overflow <= 1'b0;
    end else begin
      state         <= state_nxt;
      tmo_cnt       <= tmo_cnt_nxt;
      req_valid     <= valid_nxt;
      req_mode      <= mode_nxt;
      req_addr      <= addr_nxt;
      req_wdata     <= wdata_nxt;
      u_tx_data     <= tx_data_nxt;
      u_tx_en       <= tx_en_nxt;
      timeout_err   <= tmo_err_nxt;
      fifo_overflow <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_bus_bridge_master_ctrl.sv
// Randomized and directed bench for bus_bridge_master_ctrl against a
// transaction-level reference model compared on every cycle.
module tb_bus_bridge_master_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        u_rx_ready = 1'b0;
  logic [20:0] u_rx_data = 21'd0;
  logic        u_tx_busy = 1'b0;
  logic [7:0]  u_tx_data;
  logic        u_tx_en;
  logic        req_valid, req_mode;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_done = 1'b0;
  logic [7:0]  req_rdata = 8'd0;
  logic        fifo_overflow, timeout_err;

  bus_bridge_master_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(12), .FRAME_WIDTH(21),
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .u_rx_ready(u_rx_ready), .u_rx_data(u_rx_data),
    .u_tx_busy(u_tx_busy), .u_tx_data(u_tx_data), .u_tx_en(u_tx_en),
    .req_valid(req_valid), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_done(req_done), .req_rdata(req_rdata),
    .fifo_overflow(fifo_overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queue of frames plus the one transaction in flight
  logic [20:0] mq[$];
  logic        m_valid, m_mode, m_txen, m_ovf, m_tmo;
  logic [11:0] m_addr;
  logic [7:0]  m_wdata, m_txdata;
  bit          owed, hold;
  int          age;

  task automatic model_step();
    logic [20:0] f;
    m_txen = 1'b0;
    if (rst) begin
      mq.delete();
      m_valid = 1'b0; m_mode = 1'b0; m_addr = 12'd0; m_wdata = 8'd0;
      m_txdata = 8'd0; m_ovf = 1'b0; m_tmo = 1'b0;
      owed = 1'b0; hold = 1'b0; age = 0;
    end else begin
      if (hold) begin
        hold = 1'b0;
      end else if (owed) begin
        if (!u_tx_busy) begin
          m_txen = 1'b1; owed = 1'b0; hold = 1'b1;
        end
      end else if (m_valid) begin
        if (req_done) begin
          m_valid = 1'b0;
          if (!m_mode) begin m_txdata = req_rdata; owed = 1'b1; end
        end else if (age == TMO - 1) begin
          m_valid = 1'b0; m_tmo = 1'b1;
          if (!m_mode) begin m_txdata = 8'd0; owed = 1'b1; end
        end else begin
          age++;
        end
      end else if (mq.size() != 0) begin
        f = mq.pop_front();
        m_valid = 1'b1; m_mode = f[20]; m_wdata = f[19:12]; m_addr = f[11:0]; age = 0;
      end
      if (u_rx_ready) begin
        if (mq.size() < DEPTH) mq.push_back(u_rx_data);
        else m_ovf = 1'b1;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // per-cycle comparison plus monitors for the directed checks
  int          txen_cnt = 0;
  int          valid_len = 0;
  int          last_len = 0;
  logic        prev_valid = 1'b0;
  logic [11:0] issued[$];

  always @(posedge clk) begin
    #1;
    cmp("cyc_req_valid", req_valid, m_valid);
    if (m_valid) begin
      cmp("cyc_req_mode", req_mode, m_mode);
      cmp("cyc_req_addr", req_addr, m_addr);
      cmp("cyc_req_wdata", req_wdata, m_wdata);
    end
    cmp("cyc_u_tx_en", u_tx_en, m_txen);
    cmp("cyc_u_tx_data", u_tx_data, m_txdata);
    cmp("cyc_fifo_overflow", fifo_overflow, m_ovf);
    cmp("cyc_timeout_err", timeout_err, m_tmo);
    if (u_tx_en === 1'b1) txen_cnt++;
    if (req_valid === 1'b1) begin
      if (!prev_valid) issued.push_back(req_addr);
      valid_len++;
    end else if (prev_valid) begin
      last_len = valid_len;
      valid_len = 0;
    end
    prev_valid = req_valid;
  end

  // bus responder: 0 = never answer, 1 = answer after lat cycles, 2 = random
  int         resp_mode = 1;
  int         lat = 5;
  int         rcnt = 0;
  logic [7:0] rdata_val = 8'd0;

  always @(negedge clk) begin
    if (req_valid !== 1'b1) begin
      rcnt = 0;
      req_done = (resp_mode == 2) && ($urandom_range(0, 9) == 0);
    end else begin
      rcnt++;
      if (rcnt == 1 && resp_mode == 2) lat = $urandom_range(1, 18);
      req_done = (resp_mode != 0) && (rcnt == lat);
    end
    req_rdata = (resp_mode == 2) ? 8'($urandom) : rdata_val;
  end

  task automatic send(input logic [20:0] f);
    @(negedge clk);
    u_rx_ready = 1'b1;
    u_rx_data  = f;
    @(negedge clk);
    u_rx_ready = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    int n = 0;
    while (req_valid !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    cmp("wait_req_valid", req_valid, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int          base;
  logic [20:0] f;

  initial begin
    idle(3);
    rst = 1'b0;
    cmp("reset_req_valid", req_valid, 1'b0);
    cmp("reset_u_tx_data", u_tx_data, 8'h00);

    // single write: visible two edges after u_rx_ready, no UART traffic
    resp_mode = 1; lat = 5; base = txen_cnt;
    send(21'h1A5123);
    @(posedge clk); #1;
    cmp("wr_valid", req_valid, 1'b1);
    cmp("wr_mode", req_mode, 1'b1);
    cmp("wr_addr", req_addr, 12'h123);
    cmp("wr_wdata", req_wdata, 8'hA5);
    idle(10);
    cmp("wr_done_valid", req_valid, 1'b0);
    cmp("wr_no_tx", txen_cnt - base, 0);

    // single read returning 0x3C
    rdata_val = 8'h3C; lat = 3; base = txen_cnt;
    send(21'h000456);
    idle(15);
    cmp("rd_tx_pulses", txen_cnt - base, 1);
    cmp("rd_tx_data", u_tx_data, 8'h3C);

    // overflow: first write stalled, five frames behind it
    issued.delete(); lat = 12;
    send(21'h1000FF);
    wait_valid(10);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      u_rx_ready = 1'b1;
      u_rx_data  = {1'b1, 8'(i), 12'(i)};
    end
    @(negedge clk);
    u_rx_ready = 1'b0;
    cmp("ovf_flag", fifo_overflow, 1'b1);
    idle(100);
    cmp("ovf_issue_count", issued.size(), 5);
    for (int i = 0; i < 5 && i < issued.size(); i++)
      cmp("ovf_issue_order", issued[i], (i == 0) ? 12'h0FF : 12'(i));

    // read timeout: valid held TMO cycles, zero sent back
    resp_mode = 0; base = txen_cnt;
    send(21'h000777);
    idle(40);
    cmp("tmo_flag", timeout_err, 1'b1);
    cmp("tmo_valid_len", last_len, TMO);
    cmp("tmo_tx_pulses", txen_cnt - base, 1);
    cmp("tmo_tx_data", u_tx_data, 8'h00);

    // read response held off by a busy UART, second read waits for TX_HOLD
    resp_mode = 1; lat = 3; rdata_val = 8'h5A; u_tx_busy = 1'b1; base = txen_cnt;
    send(21'h000010);
    send(21'h000020);
    idle(20);
    cmp("busy_no_tx", txen_cnt - base, 0);
    u_tx_busy = 1'b0;
    @(posedge clk); #1;
    cmp("busy_tx_en", u_tx_en, 1'b1);
    cmp("busy_tx_data", u_tx_data, 8'h5A);
    @(posedge clk); #1;
    cmp("hold_tx_en", u_tx_en, 1'b0);
    cmp("hold_valid", req_valid, 1'b0);
    @(posedge clk); #1;
    cmp("second_valid", req_valid, 1'b1);
    cmp("second_addr", req_addr, 12'h020);
    idle(20);

    // reset during ISSUE with two frames queued
    resp_mode = 0;
    send(21'h1110AA);
    wait_valid(10);
    send(21'h1220BB);
    send(21'h1330CC);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    cmp("rst_valid", req_valid, 1'b0);
    cmp("rst_ovf", fifo_overflow, 1'b0);
    cmp("rst_tmo", timeout_err, 1'b0);
    cmp("rst_tx_data", u_tx_data, 8'h00);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmp("rst_fifo_empty", req_valid, 1'b0);
    end
    resp_mode = 1; lat = 2;
    send(21'h1440DD);
    wait_valid(10);
    cmp("post_rst_addr", req_addr, 12'h0DD);
    cmp("post_rst_wdata", req_wdata, 8'h44);
    idle(10);

    // randomized traffic
    resp_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      f = 21'($urandom);
      u_rx_ready = ($urandom_range(0, 3) == 0);
      u_rx_data  = f;
      u_tx_busy  = ($urandom_range(0, 2) == 0);
      rst        = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    u_rx_ready = 1'b0; u_tx_busy = 1'b0; rst = 1'b0;
    resp_mode = 1; lat = 2;
    idle(300);
    cmp("drain_idle", req_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
